// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Produces the IF/ID and ID/EX stall/flush controls, the EX and ID forwarding
// selects, and tracks the multi-cycle multiply/divide unit so that dependent
// HI/LO instructions are held in ID until the MDU is free.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        BranchD,
  input  logic        Jump_RD,
  input  logic        MdUseD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MdStartE,
  input  logic        MdTypeE,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MdBusy,
  output logic [15:0] StallCnt
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic        state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall, branch_stall, md_stall, stall;
  logic e_hit, m_hit;

  assign MdBusy   = (state_q == STATE_BUSY);
  assign StallCnt = stall_cnt_q;
  assign StallF   = stall;
  assign StallD   = stall;
  assign FlushE   = stall;

  // Forwarding selects; MEM result takes priority over WB, $0 never forwards,
  // and everything is held at zero while reset is asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (reset) begin
      if (RegWriteM && (WriteRegM != '0) && (WriteRegM == RsE))
        ForwardAE = 2'b10;
      else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RsE))
        ForwardAE = 2'b01;

      if (RegWriteM && (WriteRegM != '0) && (WriteRegM == RtE))
        ForwardBE = 2'b10;
      else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RtE))
        ForwardBE = 2'b01;

      ForwardAD = RegWriteM && (WriteRegM != '0) && (WriteRegM == RsD);
      ForwardBD = RegWriteM && (WriteRegM != '0) && (WriteRegM == RtD);
    end
  end

  // Stall sources: load-use, branch/jr operand not yet available in ID, and
  // HI/LO users waiting on the MDU. All sources OR into one stall.
  always_comb begin
    lw_stall     = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    e_hit        = RegWriteE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (BranchD && (WriteRegE == RtD)));
    m_hit        = MemtoRegM && (WriteRegM != '0) &&
                   ((WriteRegM == RsD) || (BranchD && (WriteRegM == RtD)));
    branch_stall = (BranchD || Jump_RD) && (e_hit || m_hit);
    md_stall     = MdUseD && (MdBusy || MdStartE);
    stall        = reset && (lw_stall || branch_stall || md_stall);
  end

  // MDU occupancy sequencer; a start while busy cannot happen in a legal
  // pipeline and is simply ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (MdStartE) begin
          cnt_d   = MdTypeE ? DIV_LOAD : MULT_LOAD;
          state_d = STATE_BUSY;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = STATE_IDLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
    endcase
  end

  // Saturating stall-cycle performance counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= STATE_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized cycles against a behavioural model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] rsd, rtd;
    logic       branchd, jrd, mdused;
    logic [4:0] rse, rte, wre;
    logic       rwe, m2re, mdstart, mdtype;
    logic [4:0] wrm;
    logic       rwm, m2rm;
    logic [4:0] wrw;
    logic       rww;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [1:0] ae, be;
    logic       ad, bd, stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  in_t  cur;

  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt;

  int passed = 0;
  int total  = 0;

  // behavioural model state
  int md_left = 0;
  int scnt    = 0;
  logic last_stall, last_busy;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .RsD(cur.rsd), .RtD(cur.rtd), .BranchD(cur.branchd), .Jump_RD(cur.jrd),
    .MdUseD(cur.mdused), .RsE(cur.rse), .RtE(cur.rte), .WriteRegE(cur.wre),
    .RegWriteE(cur.rwe), .MemtoRegE(cur.m2re), .MdStartE(cur.mdstart),
    .MdTypeE(cur.mdtype), .WriteRegM(cur.wrm), .RegWriteM(cur.rwm),
    .MemtoRegM(cur.m2rm), .WriteRegW(cur.wrw), .RegWriteW(cur.rww),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    if (cur.rwm && cur.wrm != 0 && cur.wrm == r) return 2'd2;
    if (cur.rww && cur.wrw != 0 && cur.wrw == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_hit(input logic wr, input logic [4:0] d);
    return wr && d != 0 && (d == cur.rsd || (cur.branchd && d == cur.rtd));
  endfunction

  function automatic logic m_stall();
    logic lw, br, md;
    lw = cur.m2re && cur.rte != 0 && (cur.rte == cur.rsd || cur.rte == cur.rtd);
    br = (cur.branchd || cur.jrd) && (m_hit(cur.rwe, cur.wre) || m_hit(cur.m2rm, cur.wrm));
    md = cur.mdused && (md_left > 0 || cur.mdstart);
    return lw || br || md;
  endfunction

  // One pipeline cycle: inputs already applied just after the previous edge.
  task automatic do_cycle(input bit check);
    logic s;
    #3;
    s = m_stall();
    last_stall = StallF;
    last_busy  = MdBusy;
    if (check) begin
      chk("stall_triple", {29'd0, StallF, StallD, FlushE}, {29'd0, s, s, s});
      chk("fwd_e", {28'd0, ForwardAE, ForwardBE}, {28'd0, m_fwd_e(cur.rse), m_fwd_e(cur.rte)});
      chk("fwd_d", {30'd0, ForwardAD, ForwardBD},
          {30'd0, cur.rwm && cur.wrm != 0 && cur.wrm == cur.rsd,
                  cur.rwm && cur.wrm != 0 && cur.wrm == cur.rtd});
      chk("md_busy", {31'd0, MdBusy}, {31'd0, md_left > 0});
      chk("stall_cnt", {16'd0, StallCnt}, scnt);
    end
    @(posedge clk);
    if (s) scnt = (scnt < 65535) ? scnt + 1 : 65535;
    if (md_left > 0) md_left--;
    else if (cur.mdstart) md_left = cur.mdtype ? DIV_N : MULT_N;
    #1;
  endtask

  vec_t vecs[12];
  in_t  v;
  int   ns, nb;

  initial begin
    cur   = '0;
    reset = 1'b0;
    // reset state, with inputs that would otherwise forward and stall
    cur.rse = 5; cur.rwm = 1; cur.wrm = 5; cur.rsd = 5; cur.m2re = 1; cur.rte = 5;
    @(posedge clk); #1;
    chk("rst_stall", {29'd0, StallF, StallD, FlushE}, 32'd0);
    chk("rst_fwd", {26'd0, ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 32'd0);
    chk("rst_state", {15'd0, MdBusy, StallCnt}, 32'd0);
    cur = '0;
    reset = 1'b1;
    @(posedge clk); #1;

    // directed vector table (MDU idle)
    v = '0; v.rse = 5; v.rwm = 1; v.wrm = 5; v.rww = 1; v.wrw = 5;
    vecs[0] = '{v, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    v.rwm = 0;
    vecs[1] = '{v, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    v = '0; v.rwm = 1; v.rww = 1;
    vecs[2] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    v = '0; v.m2re = 1; v.rte = 8; v.rsd = 8;
    vecs[3] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    v = '0; v.m2re = 1;
    vecs[4] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    v = '0; v.branchd = 1; v.rtd = 9; v.rwe = 1; v.wre = 9;
    vecs[5] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    v = '0; v.branchd = 1; v.rtd = 9; v.rwm = 1; v.wrm = 9;
    vecs[6] = '{v, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    v.m2rm = 1;
    vecs[7] = '{v, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    v = '0; v.jrd = 1; v.rsd = 7; v.rtd = 7; v.rwe = 1; v.wre = 7;
    vecs[8] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    v.rsd = 3;
    vecs[9] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    v = '0; v.rte = 6; v.rww = 1; v.wrw = 6; v.rsd = 6; v.rwm = 1; v.wrm = 6;
    vecs[10] = '{v, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
    v = '0; v.branchd = 1; v.rsd = 4; v.wre = 4;
    vecs[11] = '{v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cur = vecs[i].in;
      #1;
      chk($sformatf("vec%0d_fwd", i), {26'd0, ForwardAE, ForwardBE, ForwardAD, ForwardBD},
          {26'd0, vecs[i].ae, vecs[i].be, vecs[i].ad, vecs[i].bd});
      chk($sformatf("vec%0d_stall", i), {29'd0, StallF, StallD, FlushE},
          {29'd0, vecs[i].stall, vecs[i].stall, vecs[i].stall});
      do_cycle(1'b1);
    end
    cur = '0;
    do_cycle(1'b1);

    // divide then multiply with a HI/LO user held in ID
    for (int k = 0; k < 2; k++) begin
      ns = 0; nb = 0;
      for (int c = 0; c < 20; c++) begin
        cur = '0; cur.mdused = 1; cur.mdtype = (k == 0);
        cur.mdstart = (c == 0);
        do_cycle(1'b1);
        ns += last_stall; nb += last_busy;
      end
      chk(k == 0 ? "div_stalls" : "mult_stalls", ns, k == 0 ? DIV_N + 1 : MULT_N + 1);
      chk(k == 0 ? "div_busy" : "mult_busy", nb, k == 0 ? DIV_N : MULT_N);
    end

    // asynchronous reset in the 4th busy cycle of a divide
    cur = '0; cur.mdstart = 1; cur.mdtype = 1;
    do_cycle(1'b1);
    cur = '0; cur.mdused = 1;
    repeat (3) do_cycle(1'b1);
    #2;
    cur.rse = 5; cur.rwm = 1; cur.wrm = 5; cur.rsd = 5;
    reset = 1'b0;
    #1;
    chk("arst_busy_cnt", {15'd0, MdBusy, StallCnt}, 32'd0);
    chk("arst_outs", {26'd0, ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 32'd0);
    chk("arst_stall", {29'd0, StallF, StallD, FlushE}, 32'd0);
    md_left = 0; scnt = 0;
    @(negedge clk);
    reset = 1'b1;
    cur = '0; cur.mdused = 1;
    @(posedge clk); #1;
    chk("post_rst_nostall", {31'd0, StallF}, 32'd0);
    do_cycle(1'b1);
    do_cycle(1'b1);

    // randomized cycles against the model
    for (int r = 0; r < 2000; r++) begin
      cur.rsd = 5'($urandom_range(0, 3)); cur.rtd = 5'($urandom_range(0, 3));
      cur.rse = 5'($urandom_range(0, 3)); cur.rte = 5'($urandom_range(0, 3));
      cur.wre = 5'($urandom_range(0, 3)); cur.wrm = 5'($urandom_range(0, 3));
      cur.wrw = 5'($urandom_range(0, 3));
      cur.branchd = 1'($urandom); cur.jrd = 1'($urandom);
      cur.mdused = ($urandom_range(0, 3) == 0);
      cur.rwe = 1'($urandom); cur.m2re = ($urandom_range(0, 3) == 0);
      cur.mdstart = ($urandom_range(0, 7) == 0); cur.mdtype = 1'($urandom);
      cur.rwm = 1'($urandom); cur.m2rm = ($urandom_range(0, 3) == 0);
      cur.rww = 1'($urandom);
      do_cycle(1'b1);
    end

    // counter saturation and $0 load-use
    cur = '0; cur.m2re = 1; cur.rte = 8; cur.rsd = 8;
    repeat (65540) do_cycle(1'b0);
    do_cycle(1'b1);
    chk("sat_value", {16'd0, StallCnt}, 32'h0000_FFFF);
    cur = '0; cur.m2re = 1;
    #1;
    chk("zero_reg_nostall", {31'd0, StallF}, 32'd0);
    do_cycle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
